// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/bit_adder_cell.sv
// Single-bit full-adder cell, purely combinational.
module bit_adder_cell (
    input  logic x_i,
    input  logic y_i,
    input  logic carry_i,
    output logic z_o,
    output logic carry_o
);

    assign z_o     = x_i ^ y_i ^ carry_i;
    assign carry_o = (x_i & y_i) | (carry_i & (x_i ^ y_i));

endmodule

// File: rtl/serial_adder_seq.sv
// Bit-serial LSB-first adder around one bit_adder_cell; WIDTH+1 cycles per operation.
// Define SERIAL_ADDER_OVF_EN to add a two's-complement overflow output (ovf).
module serial_adder_seq
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             done_q, done_d;
    logic             cell_z, cell_co;
`ifdef SERIAL_ADDER_OVF_EN
    logic             cmsb_q, cmsb_d;
    logic             ovf_q, ovf_d;
`endif

    bit_adder_cell u_cell (
        .x_i     (a_sh_q[0]),
        .y_i     (b_sh_q[0]),
        .carry_i (carry_q),
        .z_o     (cell_z),
        .carry_o (cell_co)
    );

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        done_d  = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
        cmsb_d  = cmsb_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Sum bits enter at the MSB so bit 0 lands in place after WIDTH shifts.
                res_d   = {cell_z, res_q[WIDTH-1:1]};
                carry_d = cell_co;
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
`ifdef SERIAL_ADDER_OVF_EN
                    cmsb_d  = carry_q;
`endif
                end
            end
            DONE: begin
                sum_d   = res_q;
                cout_d  = carry_q;
                done_d  = 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
                ovf_d   = cmsb_q ^ carry_q;
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            cmsb_q  <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
            cmsb_q  <= cmsb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_seq.sv
// Self-checking bench for serial_adder_seq: arithmetic/timing model plus directed vectors.
// Define SERIAL_ADDER_OVF_EN to also exercise the ovf output.
module tb_serial_adder_seq;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         cin   = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy, done, cout;
    logic [W-1:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    serial_adder_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Model: an accepted op stays busy for W+1 cycles, then its result appears with done.
    int           age      = -1;
    logic [W:0]   pend     = '0;
    logic         pend_ovf = 1'b0;
    logic [W-1:0] exp_sum  = '0;
    logic         exp_cout = 1'b0;
    logic         exp_ovf  = 1'b0;

    function automatic logic signed_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic [W:0] r);
        return (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age      = -1;
            exp_sum  = '0;
            exp_cout = 1'b0;
            exp_ovf  = 1'b0;
        end else if (age >= 0 && age <= W) begin
            age++;
            if (age == W + 1) begin
                exp_sum  = pend[W-1:0];
                exp_cout = pend[W];
                exp_ovf  = pend_ovf;
            end
        end else if (start) begin
            pend     = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            pend_ovf = signed_ovf(a, b, pend);
            age      = 0;
        end else begin
            age = -1;
        end
    end

    always @(negedge clk) begin
        check("busy", {31'd0, busy}, {31'd0, (age >= 0 && age <= W)});
        check("done", {31'd0, done}, {31'd0, (age == W + 1)});
        check("sum",  {24'd0, sum},  {24'd0, exp_sum});
        check("cout", {31'd0, cout}, {31'd0, exp_cout});
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf",  {31'd0, ovf},  {31'd0, exp_ovf});
`endif
    end

    task automatic pulse_start(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
        @(posedge clk); #2;
        a = ta; b = tb; cin = tc; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_done(output int nbusy);
        logic ok;
        nbusy = 0;
        ok    = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (busy) nbusy++;
        end
        if (!ok) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic expect_result(input string name, input logic [W-1:0] es, input logic ec);
        int nb;
        wait_done(nb);
        check({name, "_sum"},  {24'd0, sum},  {24'd0, es});
        check({name, "_cout"}, {31'd0, cout}, {31'd0, ec});
    endtask

    task automatic count_no_done(input string name, input int n);
        int nd = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        check(name, nd, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, nd, last;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sum",  {24'd0, sum},  32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // 1: basic add, latency and busy length
        pulse_start(8'h35, 8'h4A, 1'b0);
        wait_done(nb);
        check("t1_busy_cycles", nb, W + 1);
        check("t1_sum",  {24'd0, sum},  32'h7F);
        check("t1_cout", {31'd0, cout}, 32'd0);

        // 2: carry wrap cases
        pulse_start(8'hFF, 8'h00, 1'b1);
        expect_result("t2a", 8'h00, 1'b1);
        pulse_start(8'hFF, 8'hFF, 1'b1);
        expect_result("t2b", 8'hFF, 1'b1);

        // 3: start while busy is ignored
        pulse_start(8'h0F, 8'h01, 1'b0);
        @(posedge clk); @(posedge clk); #2;
        a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        expect_result("t3_first", 8'h10, 1'b0);
        count_no_done("t3_single_done", 15);
        pulse_start(8'h11, 8'h22, 1'b0);
        expect_result("t3_second", 8'h33, 1'b0);

        // 4: reset mid-operation at count 4
        pulse_start(8'h55, 8'h0A, 1'b1);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t4_busy", {31'd0, busy}, 32'd0);
        check("t4_done", {31'd0, done}, 32'd0);
        check("t4_sum",  {24'd0, sum},  32'd0);
        check("t4_cout", {31'd0, cout}, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        count_no_done("t4_no_done", 15);
        pulse_start(8'h55, 8'h0A, 1'b1);
        expect_result("t4_after", 8'h60, 1'b0);

`ifdef SERIAL_ADDER_OVF_EN
        // 6: overflow flag
        pulse_start(8'h7F, 8'h01, 1'b0);
        expect_result("t6a", 8'h80, 1'b0);
        check("t6a_ovf", {31'd0, ovf}, 32'd1);
        pulse_start(8'h80, 8'h80, 1'b0);
        expect_result("t6b", 8'h00, 1'b1);
        check("t6b_ovf", {31'd0, ovf}, 32'd1);
        pulse_start(8'h10, 8'h20, 1'b0);
        expect_result("t6c", 8'h30, 1'b0);
        check("t6c_ovf", {31'd0, ovf}, 32'd0);
`endif

        // 5: start held high, operands change every cycle
        @(posedge clk); #2;
        start = 1'b1;
        nd    = 0;
        last  = -1;
        for (int i = 0; i < 1000 * (W + 2) + 50 && nd < 1000; i++) begin
            a   = W'($urandom);
            b   = W'($urandom);
            cin = 1'($urandom);
            @(negedge clk);
            if (done) begin
                if (last >= 0) check("t5_interval", cyc - last, W + 2);
                last = cyc;
                nd++;
            end
            @(posedge clk); #2;
        end
        check("t5_count", nd, 1000);
        start = 1'b0;
        repeat (W + 4) @(posedge clk);
        #2;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
